// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: operation codes, FSM states and
// flag bit positions within the registered {N,Z,C,V} vector.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_EOR = 3'b101;
  localparam logic [2:0] ALU_DIV = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider. The load edge already
// performs the first step, so the last step lands one cycle before the count expires.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             finished
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             div_mode;
  logic             mode;
  logic             advance;

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem_q, quot_q, divisor;

  logic [WIDTH-1:0] src_acc, src_mcand, src_mplier;
  logic [WIDTH-1:0] src_rem, src_quot, src_div;
  logic [WIDTH-1:0] nxt_acc, nxt_rem, nxt_quot;
  logic [WIDTH:0]   shifted, diff;

  assign advance  = load | (step & (cnt != '0));
  assign mode     = load ? is_div : div_mode;
  assign finished = (cnt == '0);
  assign prod_lo  = acc;
  assign quot     = quot_q;
  assign rem      = rem_q;

  // On load the step operates on fresh operands instead of the registers.
  always_comb begin
    src_acc    = acc;
    src_mcand  = mcand;
    src_mplier = mplier;
    src_rem    = rem_q;
    src_quot   = quot_q;
    src_div    = divisor;
    if (load) begin
      src_acc    = '0;
      src_mcand  = a;
      src_mplier = b;
      src_rem    = '0;
      src_quot   = a;
      src_div    = b;
    end

    nxt_acc = src_mplier[0] ? src_acc + src_mcand : src_acc;

    shifted = {src_rem, src_quot[WIDTH-1]};
    diff    = shifted - {1'b0, src_div};
    if (shifted >= {1'b0, src_div}) begin
      nxt_rem  = diff[WIDTH-1:0];
      nxt_quot = {src_quot[WIDTH-2:0], 1'b1};
    end else begin
      nxt_rem  = shifted[WIDTH-1:0];
      nxt_quot = {src_quot[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      div_mode <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      divisor  <= '0;
    end else if (advance) begin
      if (load) begin
        cnt      <= CNT_W'(WIDTH - 1);
        div_mode <= is_div;
      end else begin
        cnt <= cnt - 1'b1;
      end
      if (mode) begin
        rem_q   <= nxt_rem;
        quot_q  <= nxt_quot;
        divisor <= src_div;
      end else begin
        acc    <= nxt_acc;
        mcand  <= src_mcand << 1;
        mplier <= src_mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/ready/done handshake; single-cycle logic/arith ops,
// iterative multiply and unsigned divide, registered Result/Rem/NZCV.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Rem,
  output logic [3:0]       ALUFlags,
  output logic             div_by_zero
);

  state_t state, state_n;

  logic             accept, div_op, iter_op, sub_op, finished;
  logic             is_div_q, dbz_pend;
  logic [WIDTH-1:0] prod_lo, quot, rem_w;

  logic [WIDTH-1:0] b_eff, s_res;
  logic [WIDTH:0]   sum;
  logic             s_c, s_v;

  logic             out_en, n_c, n_v, n_dbz;
  logic [WIDTH-1:0] n_res, n_rem;
  logic [3:0]       n_flags;

  assign ready   = (state != ITER);
  assign done    = (state == DONE);
  assign accept  = start & ready;
  assign div_op  = DIV_EN && (ALUControl == ALU_DIV);
  assign iter_op = (ALUControl == ALU_MUL) || div_op;
  assign sub_op  = (ALUControl == ALU_SUB);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept & iter_op),
    .is_div   (div_op),
    .step     (state == ITER),
    .a        (a),
    .b        (b),
    .prod_lo  (prod_lo),
    .quot     (quot),
    .rem      (rem_w),
    .finished (finished)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_n = iter_op ? ITER : DONE;
        else        state_n = IDLE;
      end
      ITER:    if (finished) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Subtraction reuses the adder as a + ~b + 1 so C means "no borrow".
  always_comb begin
    b_eff = sub_op ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub_op);
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: s_res = a & b;
      ALU_OR:  s_res = a | b;
      ALU_EOR: s_res = a ^ b;
      default: s_res = '0;
    endcase
  end

  always_comb begin
    out_en = 1'b0;
    n_res  = Result;
    n_rem  = '0;
    n_c    = 1'b0;
    n_v    = 1'b0;
    n_dbz  = 1'b0;
    if (state == ITER && finished) begin
      out_en = 1'b1;
      if (is_div_q) begin
        n_res = quot;
        n_rem = rem_w;
        n_dbz = dbz_pend;
      end else begin
        n_res = prod_lo;
      end
    end else if (accept && !iter_op) begin
      out_en = 1'b1;
      n_res  = s_res;
      n_c    = s_c;
      n_v    = s_v;
    end
    n_flags         = '0;
    n_flags[FLAG_N] = n_res[WIDTH-1];
    n_flags[FLAG_Z] = (n_res == '0);
    n_flags[FLAG_C] = n_c;
    n_flags[FLAG_V] = n_v;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      is_div_q    <= 1'b0;
      dbz_pend    <= 1'b0;
      Result      <= '0;
      Rem         <= '0;
      ALUFlags    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        is_div_q <= div_op;
        dbz_pend <= div_op && (b == '0);
      end
      if (out_en) begin
        Result      <= n_res;
        Rem         <= n_rem;
        ALUFlags    <= n_flags;
        div_by_zero <= n_dbz;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU for the multi-cycle core.
- Single-cycle ops (add/sub/and/or/eor) complete in one cycle. Multiply (shift-add) and unsigned divide (restoring) iterate over WIDTH cycles.
- Uses a start/ready/done handshake so the control FSM can stall on long ops.
- Result and NZCV flags are registered and held until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.
- DIV_EN, 1, 1 = op 3'b110 performs unsigned divide; 0 = op 3'b110 is treated as illegal.
- CNT_W, $clog2(WIDTH+1), iteration counter width; localparam, not overridable.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- ALUControl  input  3  operation select, sampled on accept.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse: Result/ALUFlags/Rem valid from this cycle on.
- Result  output  WIDTH  registered result.
- Rem  output  WIDTH  division remainder; 0 for all other ops.
- ALUFlags  output  4  registered {N,Z,C,V}.
- div_by_zero  output  1  registered; 1 only after a divide with b=0.

Behaviour:
- Reset is sampled on the clk edge. While reset=0: state=IDLE, Result=0, Rem=0, ALUFlags=0, div_by_zero=0, done=0, ready=1. Reset aborts an in-flight mul/div with no done pulse.
- States:
  - IDLE: ready=1.
  - ITER: ready=0; mul/div in progress; counter counts WIDTH cycles.
  - DONE: ready=1, done=1 for exactly one cycle.
- Accept = start & ready, taken at edge t. Operands and op are latched at t; later input changes are ignored. start while ready=0 is ignored, not queued.
- Single-cycle ops go IDLE/DONE -> DONE at t; done is high in cycle t+1.
- mul/div go -> ITER for WIDTH cycles (t+1..t+WIDTH), then DONE; done is high in cycle t+WIDTH+1.
- DONE -> IDLE if no accept; a new accept in the DONE cycle is legal, giving back-to-back operations.
- Outputs change only on entry to DONE (or on reset). They hold across IDLE and ITER.
- Encodings and flags:
  - 000 add: a+b; C = carry out; V = signed overflow.
  - 001 sub: a-b computed as a+~b+1; C = carry out (1 = no borrow); V = signed overflow.
  - 010 and, 011 or, 101 eor: C=V=0.
  - 100 mul: low WIDTH bits of unsigned a*b; C=V=0.
  - 110 udiv: Result = a/b, Rem = a%b; C=V=0.
  - 111, or 110 with DIV_EN=0: illegal; single-cycle; Result=0, ALUFlags=4'b0100.
- N = Result[WIDTH-1] and Z = (Result==0) for every op.
- Divide by zero still takes WIDTH cycles and produces Result = all ones, Rem = a, div_by_zero=1. div_by_zero clears on the next DONE.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Package alu_pkg:
  - ALUControl encoding localparams (ALU_ADD..ALU_ILL).
  - FSM state enum (IDLE, ITER, DONE).
  - Flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module alu_muldiv_iter:
  - Parametrised by WIDTH.
  - Holds the shift-add multiplier and restoring divider registers plus the iteration counter.
  - Ports: load, is_div, step, a, b -> prod_lo, quot, rem.
  - Top level owns the FSM, the single-cycle ops, flags and output registers.

Test Plan:
- WIDTH=32, add a=0x7FFFFFFF b=0x00000001 -> cycle t+1: done=1, Result=0x80000000, ALUFlags=4'b1001.
- sub a=5 b=5 -> Result=0, ALUFlags=4'b0110; then sub a=0 b=1 -> Result=0xFFFFFFFF, ALUFlags=4'b1000.
- mul a=0x00010001 b=0x00010001 -> ready=0 for cycles t+1..t+32; done only at t+33; Result=0x00020001, ALUFlags=4'b0000. start pulses during ITER are ignored.
- udiv a=100 b=7 -> done at t+33, Result=14, Rem=2, div_by_zero=0.
- udiv a=100 b=0 -> Result=0xFFFFFFFF, Rem=100, div_by_zero=1, ALUFlags=4'b1000.
- reset=0 at cycle t+10 of a mul -> next cycle: done=0, ready=1, Result=0, and no later done pulse. An add accepted in the DONE cycle of a previous op completes at the following cycle.
- WIDTH=8, DIV_EN=0 instance:
  - mul 0x0F*0x11 -> Result=0xFF, done at t+9.
  - op 110 -> done at t+1, Result=0, ALUFlags=4'b0100.
